// File: rtl/psum_accumulator.sv
// Channel accumulator for 3x3 partial sums: sums N per-channel terms, requantizes
// (round, shift, optional ReLU, saturate) and queues results in a 2-entry output FIFO.
module psum_accumulator #(
  parameter int PSUM_W = 32,
  parameter int CNT_W  = 8,
  parameter int OUT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    psum_vld,
  input  logic [PSUM_W-1:0]       psum_3x3,
  output logic                    acc_stall,
  input  logic                    acc_clr,
  input  logic [CNT_W-1:0]        cfg_ch_num,
  input  logic [4:0]              cfg_shift,
  input  logic                    cfg_relu_en,
  output logic                    out_vld,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    busy
);

  // Handshake: a result transfers on a rising edge where out_vld && out_ready;
  // out_data holds steady while out_vld && !out_ready. Upstream advances only when
  // acc_stall is low, so a term is taken when psum_vld && !acc_stall && !acc_clr.

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } state_t;

  localparam logic signed [PSUM_W:0] MAX_V = (PSUM_W+1)'((1 << (OUT_W-1)) - 1);
  localparam logic signed [PSUM_W:0] MIN_V = ~MAX_V;

  state_t state_q, state_d;

  logic [PSUM_W-1:0] acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  n_q;
  logic [4:0]        shift_q;
  logic              relu_q;

  logic              accept;
  logic              last_term;
  logic              complete;
  logic [CNT_W-1:0]  n_in;
  logic [PSUM_W-1:0] sum;
  logic [4:0]        shift_eff;
  logic              relu_eff;

  logic signed [PSUM_W:0] sum_ext;
  logic signed [PSUM_W:0] bias;
  logic signed [PSUM_W:0] rnd;
  logic signed [PSUM_W:0] shifted;
  logic signed [PSUM_W:0] relu_v;
  logic signed [PSUM_W:0] clamped;
  logic [OUT_W-1:0]       quant;

  logic [OUT_W-1:0] fifo_mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  assign n_in     = (cfg_ch_num == '0) ? CNT_W'(1) : cfg_ch_num;
  assign accept   = psum_vld && !acc_stall && !acc_clr;
  assign last_term = (state_q == S_IDLE) ? (n_in == CNT_W'(1))
                                         : (cnt_q == n_q - CNT_W'(1));
  assign complete = accept && last_term;

  // The first term of a pixel uses the live config, since it is latched that same cycle.
  assign sum       = (state_q == S_IDLE) ? psum_3x3 : acc_q + psum_3x3;
  assign shift_eff = (state_q == S_IDLE) ? cfg_shift : shift_q;
  assign relu_eff  = (state_q == S_IDLE) ? cfg_relu_en : relu_q;

  // One extra bit keeps the rounding bias from overflowing.
  assign sum_ext = {sum[PSUM_W-1], sum};
  assign bias    = ({{PSUM_W{1'b0}}, 1'b1} << shift_eff) >>> 1;
  assign rnd     = sum_ext + bias;
  assign shifted = rnd >>> shift_eff;
  assign relu_v  = (relu_eff && shifted[PSUM_W]) ? '0 : shifted;

  always_comb begin
    clamped = relu_v;
    if (relu_v > MAX_V) begin
      clamped = MAX_V;
    end else if (relu_v < MIN_V) begin
      clamped = MIN_V;
    end
  end

  assign quant = clamped[OUT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (acc_clr) begin
      state_d = S_IDLE;
    end else if (accept) begin
      state_d = last_term ? S_IDLE : S_ACCUM;
    end
  end

  always_comb begin
    busy = (state_q == S_ACCUM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      n_q     <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
    end else if (acc_clr) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      acc_q <= sum;
      if (state_q == S_IDLE) begin
        n_q     <= n_in;
        shift_q <= cfg_shift;
        relu_q  <= cfg_relu_en;
      end
      if (complete) begin
        cnt_q <= '0;
      end else if (state_q == S_IDLE) begin
        cnt_q <= CNT_W'(1);
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // A push can never meet a full FIFO: terms are only accepted while count < 2.
  assign push = complete;
  assign pop  = out_vld && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_mem[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= quant;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign out_vld   = (count != 2'd0);
  assign out_data  = out_vld ? fifo_mem[rd_ptr] : '0;
  assign acc_stall = (count == 2'd2);

endmodule

// File: tb/tb_psum_accumulator.sv
// Scoreboard bench for psum_accumulator: a reference model pushes expected results
// when terms are accepted; a monitor pops and compares on each output transfer.
module tb_psum_accumulator;
  localparam int PSUM_W = 32;
  localparam int CNT_W  = 8;
  localparam int OUT_W  = 8;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    psum_vld;
  logic [PSUM_W-1:0]       psum_3x3;
  logic                    acc_stall;
  logic                    acc_clr;
  logic [CNT_W-1:0]        cfg_ch_num;
  logic [4:0]              cfg_shift;
  logic                    cfg_relu_en;
  logic                    out_vld;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic                    busy;

  psum_accumulator #(.PSUM_W(PSUM_W), .CNT_W(CNT_W), .OUT_W(OUT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .psum_vld   (psum_vld),
    .psum_3x3   (psum_3x3),
    .acc_stall  (acc_stall),
    .acc_clr    (acc_clr),
    .cfg_ch_num (cfg_ch_num),
    .cfg_shift  (cfg_shift),
    .cfg_relu_en(cfg_relu_en),
    .out_vld    (out_vld),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  bit rand_done;

  logic [OUT_W-1:0] exp_q [$];
  int               pop_cyc [$];
  logic [OUT_W-1:0] mon_data;

  logic [31:0] m_acc;
  int          m_cnt = 0;
  int          m_n = 1;
  int          m_sh = 0;
  bit          m_relu = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [OUT_W-1:0] quant_ref(input logic [31:0] s, input int sh, input bit relu);
    longint v;
    longint r;
    v = longint'($signed(s));
    if (sh > 0) v = v + (longint'(1) << (sh - 1));
    r = v >>> sh;
    if (relu && r < 0) r = 0;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r[OUT_W-1:0];
  endfunction

  task automatic model_accept(input logic [31:0] val);
    if (m_cnt == 0) begin
      m_n    = (cfg_ch_num == 0) ? 1 : int'(cfg_ch_num);
      m_sh   = int'(cfg_shift);
      m_relu = cfg_relu_en;
      m_acc  = val;
    end else begin
      m_acc = m_acc + val;
    end
    m_cnt++;
    if (m_cnt == m_n) begin
      exp_q.push_back(quant_ref(m_acc, m_sh, m_relu));
      m_cnt = 0;
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && out_vld && out_ready) begin
      pop_cyc.push_back(cyc);
      check("out_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_data = out_data;
        check("out_data", 32'(mon_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic send_term(input logic [31:0] val);
    bit accepted = 1'b0;
    psum_vld = 1'b1;
    psum_3x3 = val;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clk);
      if (!acc_stall && !acc_clr) begin
        accepted = 1'b1;
        last_acc_cyc = cyc;
        model_accept(val);
      end
    end
    if (!accepted) check("accept_timeout", 32'(accepted), 32'd1);
    @(posedge clk); #1;
    psum_vld = 1'b0;
  endtask

  task automatic set_cfg(input int n, input int sh, input bit relu);
    cfg_ch_num  = CNT_W'(n);
    cfg_shift   = 5'(sh);
    cfg_relu_en = relu;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; psum_vld = 1'b0; psum_3x3 = '0; acc_clr = 1'b0;
    out_ready = 1'b1;
    set_cfg(0, 0, 1'b0);
    repeat (3) @(negedge clk);
    mon_data = out_data;
    check("rst_out_vld", 32'(out_vld), 32'd0);
    check("rst_out_data", 32'(mon_data), 32'd0);
    check("rst_stall", 32'(acc_stall), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // three-channel sum, single pulse one cycle after the last term
    set_cfg(3, 0, 1'b0);
    pop_cyc.delete();
    send_term(32'd10);
    check("t1_busy", 32'(busy), 32'd1);
    send_term(32'd20);
    send_term(-32'sd5);
    @(negedge clk);
    check("t1_out_vld", 32'(out_vld), 32'd1);
    @(negedge clk);
    check("t1_out_vld_drop", 32'(out_vld), 32'd0);
    check("t1_pops", 32'(pop_cyc.size()), 32'd1);
    if (pop_cyc.size() == 1) check("t1_latency", 32'(pop_cyc[0]), 32'(last_acc_cyc + 1));
    wait_drain();

    // single-channel with rounding shift, outputs on consecutive cycles
    set_cfg(1, 2, 1'b0);
    pop_cyc.delete();
    send_term(32'd6);
    send_term(-32'sd6);
    send_term(32'd5);
    wait_drain();
    check("t2_pops", 32'(pop_cyc.size()), 32'd3);
    if (pop_cyc.size() == 3) begin
      check("t2_consec0", 32'(pop_cyc[1]), 32'(pop_cyc[0] + 1));
      check("t2_consec1", 32'(pop_cyc[2]), 32'(pop_cyc[1] + 1));
    end

    // saturation and ReLU
    set_cfg(2, 0, 1'b1);
    send_term(32'd300);
    send_term(32'd10);
    send_term(-32'sd40);
    send_term(-32'sd1);
    wait_drain();

    // backpressure: FIFO fills, third term held until the consumer drains
    out_ready = 1'b0;
    set_cfg(1, 0, 1'b0);
    pop_cyc.delete();
    send_term(32'd7);
    send_term(-32'sd3);
    check("t4_stall_full", 32'(acc_stall), 32'd1);
    fork
      send_term(32'd100);
      begin
        repeat (3) @(negedge clk);
        mon_data = out_data;
        check("t4_stall_held", 32'(acc_stall), 32'd1);
        check("t4_head_stable", 32'(mon_data), 32'd7);
        check("t4_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();
    check("t4_stall_drop", 32'(acc_stall), 32'd0);
    check("t4_pops", 32'(pop_cyc.size()), 32'd3);

    // abort with a coincident term, then a fresh pixel
    set_cfg(4, 0, 1'b0);
    pop_cyc.delete();
    send_term(32'd5);
    send_term(32'd6);
    acc_clr = 1'b1; psum_vld = 1'b1; psum_3x3 = 32'd99;
    @(posedge clk); #1;
    acc_clr = 1'b0; psum_vld = 1'b0;
    m_cnt = 0;
    check("t5_busy_clr", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) send_term(32'd1);
    wait_drain();
    check("t5_pops", 32'(pop_cyc.size()), 32'd1);

    // accumulator wrap with maximum shift
    set_cfg(2, 31, 1'b0);
    send_term(32'h7FFF_FFFF);
    send_term(32'd1);
    wait_drain();

    // reset with a queued result and a pixel in progress
    out_ready = 1'b0;
    set_cfg(1, 0, 1'b0);
    send_term(32'd9);
    set_cfg(3, 0, 1'b0);
    send_term(32'd2);
    check("t6_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    m_cnt = 0;
    #1;
    mon_data = out_data;
    check("t6_rst_out_vld", 32'(out_vld), 32'd0);
    check("t6_rst_out_data", 32'(mon_data), 32'd0);
    check("t6_rst_stall", 32'(acc_stall), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    pop_cyc.delete();
    @(negedge clk);
    check("t6_post_out_vld", 32'(out_vld), 32'd0);
    @(posedge clk); #1;
    set_cfg(1, 0, 1'b0);
    send_term(32'd42);
    wait_drain();
    check("t6_pops", 32'(pop_cyc.size()), 32'd1);

    // random terms, config changing under each pixel, random backpressure
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60 || m_cnt != 0; i++) begin
          set_cfg(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                  1'($urandom_range(0, 1)));
          send_term(32'($urandom_range(0, 2000)) - 32'd1000);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/psum_accumulator.md
PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

Interface
REQ-001 SHALL have parameters (name, default, meaning): PSUM_W, 32, psum and accumulator width; CNT_W, 8, channel-count width; OUT_W, 8, quantized output width.
REQ-002 SHALL have ports clk, input, 1, single clock, rising edge.
REQ-003 SHALL have ports rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports psum_vld, input, 1, psum_3x3 valid (3x3 tree output, 2-cycle delayed pipe_en).
REQ-005 SHALL have ports psum_3x3, input, PSUM_W, signed 3x3 partial sum for one input channel.
REQ-006 SHALL have ports acc_stall, output, 1, upstream backpressure; upstream pipe_en = ~acc_stall.
REQ-007 SHALL have ports acc_clr, input, 1, synchronous abort of the current accumulation.
REQ-008 SHALL have ports cfg_ch_num, input, CNT_W, number of channel terms per output pixel; 0 treated as 1.
REQ-009 SHALL have ports cfg_shift, input, 5, arithmetic right-shift amount for requantization.
REQ-010 SHALL have ports cfg_relu_en, input, 1, clamp negative results to 0.
REQ-011 SHALL have ports out_vld, output, 1; out_ready, input, 1; out_data, output, OUT_W signed; valid/ready handshake.
REQ-012 SHALL have ports busy, output, 1, high while in ACCUM.

Function
REQ-013 Term accepted in cycle t iff psum_vld && !acc_stall && !acc_clr.
REQ-014 FSM IDLE/ACCUM: IDLE + accepted term -> acc=psum_3x3, cnt=1, latch cfg_ch_num/cfg_shift/cfg_relu_en; move to ACCUM unless latched N==1 (then complete, stay IDLE).
REQ-015 ACCUM + accepted term -> acc=acc+psum_3x3 (modulo 2^PSUM_W, wrap, no saturation), cnt+1; when cnt==N-1 before add, complete and return to IDLE.
REQ-016 cfg_* changes during ACCUM SHALL NOT affect the pixel in progress.
REQ-017 Completion: sum S (final acc value incl. last term); shift s: R = (S + (s>0 ? 2^(s-1) : 0)) >>> s computed in PSUM_W+1 bits (round half up, no overflow).
REQ-018 If relu latched, R<0 -> 0; then saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-019 Quantized result pushed into 2-entry output FIFO in completion cycle; out_vld high from t+1 when FIFO was empty.
REQ-020 out_data = FIFO head; pop when out_vld && out_ready; in-order; out_data stable while out_vld && !out_ready.
REQ-021 acc_stall = (FIFO count == 2), combinational from registered count; no term accepted while stalled, acc and cnt hold.
REQ-022 Simultaneous push and pop with count==1: count stays 1, head advances, new entry becomes tail.
REQ-023 acc_clr: next cycle state=IDLE, acc=0, cnt=0; FIFO contents and out_vld unaffected; wins over a coincident psum_vld (term dropped).
REQ-024 psum_vld while acc_stall: term not consumed; upstream holds it (pipe_en low freezes its pipeline).

Reset
REQ-025 rst_n low (asynchronous): state=IDLE, acc=0, cnt=0, latched cfg=0, FIFO empty, out_vld=0, out_data=0, acc_stall=0, busy=0.
REQ-026 Reset mid-accumulation or with FIFO occupied discards all partial and queued results; first cycle after release behaves as fresh IDLE.

Verification
REQ-027 cfg_ch_num=3, shift=0, relu=0, terms 10,20,-5 back-to-back, out_ready=1 -> one out_vld pulse, out_data=25, cycle after third term.
REQ-028 cfg_ch_num=1, shift=2, terms 6,-6,5 -> outputs 2 (6+2>>>2), -1 ((-6+2)>>>2), 1; three consecutive out_vld cycles.
REQ-029 cfg_ch_num=2, shift=0, relu=1, terms 300,10 then -40,-1 -> outputs 127 (saturated), 0 (ReLU).
REQ-030 out_ready=0, ch_num=1, three valid terms -> two results queued, acc_stall=1 after second, third held; out_ready=1 -> all three delivered in order, stall drops.
REQ-031 ch_num=4, two terms, acc_clr pulse with coincident psum_vld, then 4 terms of 1 -> single output 4; no output from aborted pixel.
REQ-032 Terms 0x7FFFFFFF,1 with ch_num=2, shift=31 -> acc wraps to 0x80000000, R=-1 -> out_data=-1; rst_n low mid-pixel -> all outputs at reset values.
